// File: rtl/mem_access_unit_if.sv
// Word-wide data bus between the MEM stage and memory.
// The master (mem_access_unit) issues requests; the slave grants them and returns read data.
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM pipeline stage.
// - Runs loads and stores on a variable-latency word bus.
// - Stalls upstream until each access completes.
// - Holds the MEM/WB register, with the write-back data already selected.
// Optional feature macro MEM_TIMEOUT_EN adds a bus-response watchdog:
//   on expiry the access completes with 32'hDEADBEEF and bus_err is set sticky.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic        MEM_RegWrite,
  input  logic [1:0]  MEM_MemtoReg,
  input  logic [31:0] MEM_ALU_out,
  input  logic [31:0] MEM_Data_in2,
  input  logic [31:0] MEM_PC_plus_4,
  input  logic [4:0]  MEM_Write_register,
  output logic        mem_stall,
  mem_access_unit_if.master bus,
  output logic        WB_RegWrite,
  output logic [4:0]  WB_Write_register,
  output logic [31:0] WB_Write_data,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, RESP, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic [4:0]  wb_dest_q, wb_dest_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [31:0] wb_sel;

  logic pending, is_write, idle_req, stall, to_hit;

  // A request with both bits set is treated as a write.
  assign pending  = MEM_MemRead | MEM_MemWrite;
  assign is_write = MEM_MemWrite;
  assign idle_req = (state_q == IDLE) && pending;
  assign stall    = idle_req || (state_q == RESP);

  // The request is gated by reset so that it drops the moment reset asserts.
  // It does not wait for the asynchronous state clear to propagate.
  assign bus.bus_req   = reset & idle_req;
  assign bus.bus_we    = is_write;
  assign bus.bus_addr  = {MEM_ALU_out[31:2], 2'b00};
  assign bus.bus_wdata = MEM_Data_in2;
  assign mem_stall     = reset & stall;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       counting;

  // Count cycles spent waiting on the bus.
  // Expiry fires on the TIMEOUT_CYCLES-th waiting cycle.
  assign counting = idle_req || (state_q == RESP);
  assign to_hit   = counting && (cnt_q == TO_LAST);

  // Next watchdog count and sticky error flag.
  always_comb begin
    cnt_d = counting ? cnt_q + 8'd1 : 8'd0;
    err_d = err_q | to_hit;
  end

  // Watchdog registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus_err = err_q;
`else
  // Without the watchdog the limit has no meaning. It is kept only to hold the parameter list stable.
  localparam int timeout_unused = TIMEOUT_CYCLES;
  assign to_hit  = 1'b0;
  assign bus_err = 1'b0;
`endif

  // Access sequencing.
  // Watchdog expiry overrides any bus event in the same cycle.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE:    if (pending && bus.bus_gnt) state_d = is_write ? DONE : RESP;
      RESP:    if (bus.bus_rvalid) begin
                 rdata_d = bus.bus_rdata;
                 state_d = DONE;
               end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (to_hit) begin
      state_d = DONE;
      rdata_d = 32'hDEADBEEF;
    end
  end

  // Write-back source select.
  // MemtoReg 11 falls through to the ALU result.
  always_comb begin
    unique case (MEM_MemtoReg)
      2'b01:   wb_sel = rdata_q;
      2'b10:   wb_sel = MEM_PC_plus_4;
      default: wb_sel = MEM_ALU_out;
    endcase
  end

  // MEM/WB next value.
  // A stall inserts a bubble by clearing RegWrite and holding the other fields.
  always_comb begin
    wb_regwrite_d = stall ? 1'b0      : MEM_RegWrite;
    wb_dest_d     = stall ? wb_dest_q : MEM_Write_register;
    wb_data_d     = stall ? wb_data_q : wb_sel;
  end

  // State, read-data and MEM/WB registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      rdata_q       <= 32'd0;
      wb_regwrite_q <= 1'b0;
      wb_dest_q     <= 5'd0;
      wb_data_q     <= 32'd0;
    end else begin
      state_q       <= state_d;
      rdata_q       <= rdata_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_dest_q     <= wb_dest_d;
      wb_data_q     <= wb_data_d;
    end
  end

  assign WB_RegWrite       = wb_regwrite_q;
  assign WB_Write_register = wb_dest_q;
  assign WB_Write_data     = wb_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit.
// - The driver runs one instruction at a time and plays the bus slave.
// - A reference model predicts stall length and write-back contents.
// - A monitor pops the predicted write-back whenever the stage completes.
module tb_mem_access_unit;
`ifdef MEM_TIMEOUT_EN
  localparam int TO_P = 4;
`else
  localparam int TO_P = 255;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mr = 1'b0, mw = 1'b0, rwr = 1'b0;
  logic [1:0]  m2r = 2'd0;
  logic [31:0] alu = 32'd0, d2 = 32'd0, pc4 = 32'd0;
  logic [4:0]  wreg = 5'd0;
  logic        mem_stall, WB_RegWrite, bus_err;
  logic [4:0]  WB_Write_register;
  logic [31:0] WB_Write_data;

  mem_access_unit_if bus();

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(TO_P)) dut (
    .clk(clk), .reset(reset),
    .MEM_MemRead(mr), .MEM_MemWrite(mw), .MEM_RegWrite(rwr),
    .MEM_MemtoReg(m2r), .MEM_ALU_out(alu), .MEM_Data_in2(d2),
    .MEM_PC_plus_4(pc4), .MEM_Write_register(wreg),
    .mem_stall(mem_stall), .bus(bus),
    .WB_RegWrite(WB_RegWrite), .WB_Write_register(WB_Write_register),
    .WB_Write_data(WB_Write_data), .bus_err(bus_err)
  );

  typedef struct packed {
    logic        rw;
    logic [4:0]  dest;
    logic [31:0] data;
  } wb_t;

  wb_t         exp_q[$];
  int          checks = 0, errors = 0;
  logic [31:0] m_rdata = 32'd0;
  logic        m_err = 1'b0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a cycle sampled with mem_stall=0 must deliver the next predicted write-back.
  // A cycle sampled with mem_stall=1 must leave a bubble.
  bit pend = 1'b0, prev_stall = 1'b0;
  always @(negedge clk) begin
    if (!reset || !mon_en) begin
      pend = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (pend) begin
        if (exp_q.size() == 0) check("wb_unexpected", {WB_RegWrite, WB_Write_register, WB_Write_data}, 64'hx);
        else check("wb_result", {WB_RegWrite, WB_Write_register, WB_Write_data}, exp_q.pop_front());
      end else if (prev_stall) begin
        check("wb_bubble", WB_RegWrite, 1'b0);
      end
      pend = !mem_stall;
      prev_stall = mem_stall;
    end
  end

  // Present one instruction and act as bus slave.
  // gw       = cycles without grant before the grant cycle.
  // rvw      = RESP cycles without rvalid before the rvalid cycle.
  // stray_en = allow random rvalid pulses in cycles where the unit must ignore them.
  task automatic run_instr(input logic rd, input logic wr, input logic rw, input logic [1:0] ms,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] p4,
                           input logic [4:0] dst, input int gw, input int rvw,
                           input logic [31:0] rdat, input bit stray_en);
    bit mem, ld, to_hit, got, exp_req;
    int n, stall, c;
    wb_t e;
    mem = rd | wr;
    ld  = rd & !wr;
    n = !mem ? 0 : (wr ? gw + 1 : gw + rvw + 2);
    to_hit = 1'b0;
`ifdef MEM_TIMEOUT_EN
    if (mem && n >= TO_P) to_hit = 1'b1;
`endif
    stall = to_hit ? TO_P : n;
    if (to_hit) m_rdata = 32'hDEADBEEF;
    else if (ld) m_rdata = rdat;
    m_err = m_err | to_hit;
    e.rw   = rw;
    e.dest = dst;
    e.data = (ms == 2'b01) ? m_rdata : (ms == 2'b10) ? p4 : a;
    exp_q.push_back(e);

    mr = rd; mw = wr; rwr = rw; m2r = ms; alu = a; d2 = wd; pc4 = p4; wreg = dst;
    mon_en = 1'b1;
    got = 1'b0;
    for (c = 0; c <= stall + 20 && !got; c++) begin
      bus.bus_gnt = mem && (c == gw);
      if (ld && c == gw + 1 + rvw) begin
        bus.bus_rvalid = 1'b1;
        bus.bus_rdata  = rdat;
      end else begin
        bus.bus_rvalid = stray_en && (!ld || c <= gw || c == stall) && ($urandom_range(0, 1) == 1);
        bus.bus_rdata  = $urandom;
      end
      @(negedge clk);
      exp_req = mem && (c <= gw) && (c < stall);
      check("bus_req", bus.bus_req, exp_req);
      if (exp_req)
        check("bus_fields", {bus.bus_we, bus.bus_addr, bus.bus_wdata}, {wr, a & 32'hFFFF_FFFC, wd});
      if (!mem_stall) begin
        got = 1'b1;
        check("stall_cycles", c, stall);
        check("bus_err", bus_err, m_err);
      end
      @(posedge clk);
      #1;
    end
    if (!got) check("stall_bound", c, stall);
    bus.bus_gnt = 1'b0;
    bus.bus_rvalid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    bus.bus_gnt = 1'b0;
    bus.bus_rvalid = 1'b0;
    bus.bus_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wb", {WB_RegWrite, WB_Write_register, WB_Write_data}, 38'd0);
    check("rst_err", bus_err, 1'b0);
    check("rst_req", bus.bus_req, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases.
    run_instr(0, 0, 1, 2'b00, 32'h12, 32'h0, 32'h4, 5'd5, 0, 0, 32'h0, 0);
    run_instr(1, 0, 1, 2'b01, 32'h1003, 32'h0, 32'h8, 5'd7, 2, 2, 32'hCAFEF00D, 0);
    run_instr(0, 1, 0, 2'b00, 32'h2000, 32'hA5A5A5A5, 32'hC, 5'd9, 0, 0, 32'h0, 0);
    run_instr(1, 0, 1, 2'b01, 32'h3000, 32'h0, 32'h10, 5'd1, 0, 0, 32'h11112222, 0);
    run_instr(1, 0, 1, 2'b01, 32'h3004, 32'h0, 32'h14, 5'd2, 0, 0, 32'h33334444, 0);
    run_instr(0, 0, 1, 2'b01, 32'h55, 32'h0, 32'h18, 5'd3, 0, 0, 32'h0, 1);
    run_instr(0, 0, 1, 2'b10, 32'h55, 32'h0, 32'h1C, 5'd4, 0, 0, 32'h0, 0);
    run_instr(0, 0, 1, 2'b11, 32'h66, 32'h0, 32'h20, 5'd6, 0, 0, 32'h0, 0);
    run_instr(1, 1, 1, 2'b01, 32'h4002, 32'h77, 32'h24, 5'd8, 1, 0, 32'h0, 1);
    run_instr(1, 0, 1, 2'b01, 32'h5000, 32'h0, 32'h28, 5'd10, 0, 10, 32'h99998888, 0);

    // Randomized mix.
    for (int i = 0; i < 60; i++) begin
      int k;
      k = $urandom_range(0, 3);
      run_instr(k == 1 || k == 3, k == 2 || k == 3, 1'($urandom), 2'($urandom),
                $urandom, $urandom, $urandom, 5'($urandom),
                $urandom_range(0, 4), $urandom_range(0, 3), $urandom, 1);
    end
    run_instr(0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0, 0);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("queue_drained", exp_q.size(), 0);

    // Reset during RESP, then a stray rvalid after release.
    mr = 1'b1; mw = 1'b0; rwr = 1'b1; m2r = 2'b01; alu = 32'h40; wreg = 5'd3;
    bus.bus_gnt = 1'b1;
    @(posedge clk);
    #1;
    bus.bus_gnt = 1'b0;
    @(negedge clk);
    check("resp_stall", mem_stall, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    check("rst_req_drop", bus.bus_req, 1'b0);
    check("rst2_wb", {WB_RegWrite, WB_Write_register, WB_Write_data}, 38'd0);
    check("rst2_err", bus_err, 1'b0);
    mr = 1'b0; rwr = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.bus_rvalid = 1'b1;
    bus.bus_rdata = 32'h1234;
    @(posedge clk);
    #1;
    bus.bus_rvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_stall", mem_stall, 1'b0);
    check("post_rst_wb", {WB_RegWrite, WB_Write_data}, 33'd0);
    check("post_rst_req", bus.bus_req, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage consumer of the EX/MEM pipeline register. It takes the memory-stage control and data fields, runs load/store accesses on a variable-latency word-wide data bus, stalls the pipeline until each access completes, and holds the MEM/WB pipeline register feeding write-back, with the write-back data already selected. It also optionally enforces a bus-response watchdog.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: watchdog limit in cycles. Used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; one clock domain.
- MEM_MemRead, MEM_MemWrite, MEM_RegWrite  in  1 each  control bits from the EX/MEM register.
- MEM_MemtoReg  in  2  write-back source: 00 ALU, 01 memory, 10 PC+4; 11 behaves as 00.
- MEM_ALU_out  in  32  address or ALU result.
- MEM_Data_in2  in  32  store data.
- MEM_PC_plus_4  in  32  link value.
- MEM_Write_register  in  5  destination register.
- mem_stall  out  1  holds PC, IF/ID, ID/EX and EX/MEM.
- bus_req, bus_we  out  1  access request; 1 = write.
- bus_addr  out  32  {MEM_ALU_out[31:2],2'b00}.
- bus_wdata  out  32  MEM_Data_in2.
- bus_gnt  in  1  request accepted this cycle.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  32  read data.
- WB_RegWrite  out  1  registered write enable.
- WB_Write_register  out  5  registered destination.
- WB_Write_data  out  32  registered, muxed write-back data.
- bus_err  out  1  sticky watchdog flag.

## Operation
- Access pending = MEM_MemRead | MEM_MemWrite. If both bits are set, treat the access as a write.
- FSM states: IDLE, RESP, DONE.
  - IDLE, no access pending: mem_stall=0, bus_req=0. The MEM/WB register loads every cycle.
  - IDLE, access pending: bus_req=1 and mem_stall=1, both combinational. On bus_gnt, a write goes to DONE and a read goes to RESP. Without bus_gnt, stay in IDLE and keep the request stable.
  - RESP: bus_req=0, mem_stall=1. On bus_rvalid, capture bus_rdata into rdata_q and go to DONE. bus_rvalid in any other state is ignored.
  - DONE: mem_stall=0, bus_req=0. The MEM/WB register loads the instruction. Unconditionally return to IDLE.
- While mem_stall=1, the MEM/WB register loads a bubble: WB_RegWrite=0, other fields unchanged.
- WB_Write_data mux:
  - MemtoReg 01 selects rdata_q.
  - MemtoReg 10 selects MEM_PC_plus_4.
  - Otherwise selects MEM_ALU_out.
- Upstream holds the EX/MEM fields stable while mem_stall=1. This block does not re-latch them.

## Timing
- Reset values: state IDLE, WB_RegWrite 0, WB_Write_register 0, WB_Write_data 0, rdata_q 0, bus_err 0, watchdog count 0.
- bus_req drops in the same instant reset asserts.
- Non-memory instruction: zero stall cycles. Its result is visible on WB_* one cycle after it is presented.
- Store with same-cycle gnt: 1 stall cycle. WB_* update at the end of the DONE cycle.
- Load with same-cycle gnt and rvalid on the next cycle: 2 stall cycles.
- Each cycle without gnt or rvalid adds one stall cycle.
- bus_rvalid is never expected in the gnt cycle. If it occurs there, it is ignored.
- Back-to-back accesses: the instruction after DONE re-enters IDLE. A pending access requests in the cycle right after DONE, so there are no idle bubbles between accesses.
- Reset during RESP: return to IDLE. A late bus_rvalid after reset release is ignored.

## Configuration
- MEM_TIMEOUT_EN defined:
  - An 8-bit counter increments each cycle in IDLE-with-request or in RESP.
  - It clears in DONE and in IDLE without a request.
  - When the counter reaches TIMEOUT_CYCLES: go to DONE, set rdata_q=32'hDEADBEEF (for both reads and writes), and set bus_err=1 sticky until reset.
- MEM_TIMEOUT_EN undefined:
  - No counter is built. The block waits indefinitely.
  - bus_err is tied to 0 and TIMEOUT_CYCLES is unused.

## Test plan
- ALU instruction (ALU_out=0x12, RegWrite=1, dest 5, MemtoReg 00) -> mem_stall never asserts; next cycle WB_Write_data=0x12, WB_Write_register=5, WB_RegWrite=1.
- Load from 0x1003 with gnt after 2 cycles and rvalid 3 cycles after gnt, rdata=0xCAFEF00D -> bus_addr=0x1000; 6 stall cycles; bubbles on WB meanwhile; then WB_Write_data=0xCAFEF00D.
- Store of 0xA5A5A5A5 to 0x2000 with immediate gnt -> one cycle of bus_req with bus_we=1 and bus_wdata=0xA5A5A5A5; exactly 1 stall cycle; WB_RegWrite=0 when RegWrite=0.
- Two back-to-back loads with zero-wait bus -> second bus_req rises in the cycle after the first DONE; each load stalls 2 cycles.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, load granted but no rvalid -> DONE after the 4th counted cycle; WB_Write_data=0xDEADBEEF; bus_err=1 and held.
- reset pulled low in RESP, then rvalid pulses after release -> all outputs at reset values; state IDLE; WB unchanged by the stray rvalid.
